// File: rtl/alu_pkg.sv
// alu_pkg: shared op, flag and state types for the ALU op sequencer
// Contents: op_e (ALU op select), flags_t ({n,z,c,v}), state_e (sequencer FSM states)
package alu_pkg;
  typedef enum logic [2:0] {
    OP_1 = 3'b000, OP_2, OP_3, OP_4, OP_5, OP_6, OP_7, OP_ILLEGAL
  } op_e;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE} state_e;
endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command, ALU and result buses of the ALU op sequencer
// Signals: cmd_* (command valid/ready handshake), alu_* (op/operands out, result/flags in),
// res_* (result valid/ready handshake). slave = sequencer side, master = controller/ALU side.
interface alu_op_sequencer_if #(parameter int P = 4, parameter int CNT_W = 4);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [P-1:0]     cmd_a;
  logic [P-1:0]     cmd_b;
  logic [CNT_W-1:0] cmd_count;
  logic [2:0]       alu_op;
  logic [P-1:0]     alu_a;
  logic [P-1:0]     alu_b;
  logic [P-1:0]     alu_result;
  logic [3:0]       alu_flags;
  logic             res_valid;
  logic             res_ready;
  logic [P-1:0]     res_data;
  logic [3:0]       res_flags;
  logic             res_err;
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_count, alu_result, alu_flags, res_ready,
    output cmd_ready, alu_op, alu_a, alu_b, res_valid, res_data, res_flags, res_err
  );
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_count, alu_result, alu_flags, res_ready,
    input  cmd_ready, alu_op, alu_a, alu_b, res_valid, res_data, res_flags, res_err
  );
endinterface

// File: rtl/alu_op_seq_stats.sv
// alu_op_seq_stats: saturating completed-command and iteration counters
// Ports: clk, rst_n (async active-low), clr (sync clear, beats increment),
// cmd_done/iter (increment strobes), stat_cmds/stat_iters (16-bit counts)
module alu_op_seq_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        cmd_done,
  input  logic        iter,
  output logic [15:0] stat_cmds,
  output logic [15:0] stat_iters
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cmds  <= '0;
      stat_iters <= '0;
    end else if (clr) begin
      stat_cmds  <= '0;
      stat_iters <= '0;
    end else begin
      if (cmd_done && stat_cmds != 16'hFFFF) stat_cmds <= stat_cmds + 16'd1;
      if (iter && stat_iters != 16'hFFFF) stat_iters <= stat_iters + 16'd1;
    end
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sequences repeated ALU ops, feeding the result back as operand A
// Ports: clk, rst_n (async active-low), bus (alu_op_sequencer_if.slave: cmd/alu/res buses),
// busy (state != IDLE). With ALU_OP_SEQ_STATS_EN defined also stat_clr, stat_cmds, stat_iters.
// Params: P data width, CNT_W repeat-count width, ALU_LAT settle cycles (0..3) before capture.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int P       = 4,
  parameter int CNT_W   = 4,
  parameter int ALU_LAT = 0
) (
  input  logic clk,
  input  logic rst_n,
  alu_op_sequencer_if.slave bus,
  output logic busy
`ifdef ALU_OP_SEQ_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] stat_cmds,
  output logic [15:0] stat_iters
`endif
);
  state_e           state, nxt;
  op_e              op;
  logic [P-1:0]     acc, b, rdata;
  logic [CNT_W-1:0] rem;
  logic [1:0]       wcnt;
  flags_t           flags;
  logic             err;
  logic             last, wait_done;
  assign last      = rem == CNT_W'(1);
  assign wait_done = wcnt == 2'(ALU_LAT - 1);
  assign bus.cmd_ready = state == S_IDLE;
  assign bus.res_valid = state == S_DONE;
  assign bus.res_data  = rdata;
  assign bus.res_flags = flags;
  assign bus.res_err   = err;
  assign busy          = state != S_IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:    nxt = !bus.cmd_valid ? S_IDLE : (bus.cmd_op == OP_ILLEGAL ? S_DONE : S_ISSUE);
      S_ISSUE:   nxt = ALU_LAT > 0 ? S_WAIT : S_CAPTURE;
      S_WAIT:    nxt = wait_done ? S_CAPTURE : S_WAIT;
      S_CAPTURE: nxt = last ? S_DONE : S_ISSUE;
      S_DONE:    nxt = bus.res_ready ? S_IDLE : S_DONE;
      default:   nxt = S_IDLE;
    endcase
  end
  // ALU drive registers only change in ISSUE, so the ALU sees stable inputs through WAIT/CAPTURE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op          <= OP_1;
      acc         <= '0;
      b           <= '0;
      rdata       <= '0;
      rem         <= '0;
      wcnt        <= '0;
      flags       <= '0;
      err         <= 1'b0;
      bus.alu_op  <= '0;
      bus.alu_a   <= '0;
      bus.alu_b   <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (bus.cmd_valid) begin
          op  <= op_e'(bus.cmd_op);
          acc <= bus.cmd_a;
          b   <= bus.cmd_b;
          rem <= bus.cmd_count == '0 ? CNT_W'(1) : bus.cmd_count;
          if (bus.cmd_op == OP_ILLEGAL) begin
            rdata <= '0;
            flags <= '0;
            err   <= 1'b1;
          end
        end
        S_ISSUE: begin
          bus.alu_op <= op;
          bus.alu_a  <= acc;
          bus.alu_b  <= b;
          wcnt       <= '0;
        end
        S_WAIT: wcnt <= wcnt + 2'd1;
        S_CAPTURE: begin
          acc   <= bus.alu_result;
          rdata <= bus.alu_result;
          flags <= flags_t'(bus.alu_flags);
          rem   <= rem - CNT_W'(1);
        end
        S_DONE: if (bus.res_ready) err <= 1'b0;
        default: ;
      endcase
    end
  end
`ifdef ALU_OP_SEQ_STATS_EN
  alu_op_seq_stats u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (stat_clr),
    .cmd_done   (state == S_DONE && bus.res_ready),
    .iter       (state == S_CAPTURE),
    .stat_cmds  (stat_cmds),
    .stat_iters (stat_iters)
  );
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed self-checking bench for alu_op_sequencer (ALU_LAT=0 and 2 instances)
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy0, busy2;
  int   nvec = 0;
  int   nerr = 0;
  always #5 clk = ~clk;
  alu_op_sequencer_if #(.P(4), .CNT_W(4)) b0 ();
  alu_op_sequencer_if #(.P(4), .CNT_W(4)) b2 ();
`ifdef ALU_OP_SEQ_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] sc0, si0, sc2, si2;
`endif
  alu_op_sequencer #(.P(4), .CNT_W(4), .ALU_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .busy(busy0)
`ifdef ALU_OP_SEQ_STATS_EN
    , .stat_clr(stat_clr), .stat_cmds(sc0), .stat_iters(si0)
`endif
  );
  alu_op_sequencer #(.P(4), .CNT_W(4), .ALU_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2), .busy(busy2)
`ifdef ALU_OP_SEQ_STATS_EN
    , .stat_clr(stat_clr), .stat_cmds(sc2), .stat_iters(si2)
`endif
  );
  // ALU model: 000 add, 001 sub (c = carry / borrow), returns {n,z,c,v,result}
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] bb);
    logic [4:0] s;
    logic       v;
    if (op == 3'b001) begin
      s = {1'b0, a} - {1'b0, bb};
      v = (a[3] != bb[3]) && (s[3] != a[3]);
    end else begin
      s = {1'b0, a} + {1'b0, bb};
      v = (a[3] == bb[3]) && (s[3] != a[3]);
    end
    return {s[3], s[3:0] == 4'd0, s[4], v, s[3:0]};
  endfunction
  assign {b0.alu_flags, b0.alu_result} = alu_f(b0.alu_op, b0.alu_a, b0.alu_b);
  assign {b2.alu_flags, b2.alu_result} = alu_f(b2.alu_op, b2.alu_a, b2.alu_b);
  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] bb,
                      input logic [3:0] cnt, output int n);
    b0.cmd_op = op;
    b0.cmd_a = a;
    b0.cmd_b = bb;
    b0.cmd_count = cnt;
    b0.cmd_valid = 1'b1;
    @(posedge clk); #1;
    b0.cmd_valid = 1'b0;
    n = 1;
    while (!b0.res_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask
  task automatic test_reset();
    logic [22:0] got0, got2;
    rst_n = 1'b0;
    #12;
    got0 = {b0.cmd_ready, b0.res_valid, b0.res_data, b0.res_flags, b0.res_err, b0.alu_op, b0.alu_a, b0.alu_b, busy0};
    got2 = {b2.cmd_ready, b2.res_valid, b2.res_data, b2.res_flags, b2.res_err, b2.alu_op, b2.alu_a, b2.alu_b, busy2};
    nvec++;
    if (got0 !== {1'b1, 22'b0}) begin nerr++; $display("FAIL reset_lat0: got %h want %h", got0, {1'b1, 22'b0}); end
    nvec++;
    if (got2 !== {1'b1, 22'b0}) begin nerr++; $display("FAIL reset_lat2: got %h want %h", got2, {1'b1, 22'b0}); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_single();
    int n;
    b0.res_ready = 1'b1;
    send(3'b000, 4'd3, 4'd4, 4'd1, n);
    nvec++;
    if (n !== 3) begin nerr++; $display("FAIL single_latency: got %0d want 3", n); end
    nvec++;
    if (b0.res_data !== 4'd7) begin nerr++; $display("FAIL single_data: got %0d want 7", b0.res_data); end
    nvec++;
    if (b0.res_flags !== 4'b0000) begin nerr++; $display("FAIL single_flags: got %b want 0000", b0.res_flags); end
    nvec++;
    if (b0.res_err !== 1'b0) begin nerr++; $display("FAIL single_err: got %b want 0", b0.res_err); end
    @(posedge clk); #1;
    nvec++;
    if (b0.cmd_ready !== 1'b1) begin nerr++; $display("FAIL single_idle: got %b want 1", b0.cmd_ready); end
  endtask
  task automatic test_chain();
    int n;
`ifdef ALU_OP_SEQ_STATS_EN
    logic [15:0] it0 = si0;
    logic [15:0] cm0 = sc0;
`endif
    send(3'b000, 4'd9, 4'd3, 4'd3, n);
    nvec++;
    if (n !== 7) begin nerr++; $display("FAIL chain_latency: got %0d want 7", n); end
    nvec++;
    if (b0.res_data !== 4'd2) begin nerr++; $display("FAIL chain_data: got %0d want 2", b0.res_data); end
    nvec++;
    if (b0.res_flags !== 4'b0010) begin nerr++; $display("FAIL chain_flags: got %b want 0010", b0.res_flags); end
    @(posedge clk); #1;
`ifdef ALU_OP_SEQ_STATS_EN
    nvec++;
    if (si0 !== it0 + 16'd3) begin nerr++; $display("FAIL chain_stat_iters: got %0d want %0d", si0, it0 + 16'd3); end
    nvec++;
    if (sc0 !== cm0 + 16'd1) begin nerr++; $display("FAIL chain_stat_cmds: got %0d want %0d", sc0, cm0 + 16'd1); end
`endif
  endtask
  task automatic test_backpressure();
    int n;
    logic [10:0] got;
    b0.res_ready = 1'b0;
    send(3'b001, 4'd5, 4'd5, 4'd0, n);
    nvec++;
    if (n !== 3) begin nerr++; $display("FAIL bp_latency: got %0d want 3", n); end
    for (int i = 0; i < 10; i++) begin
      b0.cmd_valid = (i % 2 == 0);
      b0.cmd_op = 3'b000;
      b0.cmd_a = 4'(i);
      b0.cmd_count = 4'd1;
      @(posedge clk); #1;
      got = {b0.res_valid, b0.cmd_ready, b0.res_data, b0.res_flags, busy0};
      nvec++;
      if (got !== 11'b1_0_0000_0100_1) begin nerr++; $display("FAIL bp_hold[%0d]: got %b want 10000001001", i, got); end
    end
    b0.cmd_valid = 1'b0;
    b0.res_ready = 1'b1;
    @(posedge clk); #1;
    nvec++;
    if ({b0.res_valid, b0.cmd_ready, busy0} !== 3'b010) begin
      nerr++; $display("FAIL bp_release: got %b want 010", {b0.res_valid, b0.cmd_ready, busy0});
    end
    @(posedge clk); #1;
    nvec++;
    if ({b0.res_valid, busy0} !== 2'b00) begin nerr++; $display("FAIL bp_no_ghost: got %b want 00", {b0.res_valid, busy0}); end
  endtask
  task automatic test_illegal();
    int n;
    send(3'b111, 4'hF, 4'd2, 4'd5, n);
    nvec++;
    if (n !== 1) begin nerr++; $display("FAIL illegal_latency: got %0d want 1", n); end
    nvec++;
    if ({b0.res_err, b0.res_data, b0.res_flags} !== 9'b1_0000_0000) begin
      nerr++; $display("FAIL illegal_result: got %b want 100000000", {b0.res_err, b0.res_data, b0.res_flags});
    end
    nvec++;
    if (b0.alu_op !== 3'b001) begin nerr++; $display("FAIL illegal_alu_op: got %b want 001", b0.alu_op); end
    @(posedge clk); #1;
    nvec++;
    if ({b0.res_valid, b0.res_err, b0.cmd_ready, b0.alu_op} !== 6'b001_001) begin
      nerr++; $display("FAIL illegal_clear: got %b want 001001", {b0.res_valid, b0.res_err, b0.cmd_ready, b0.alu_op});
    end
  endtask
  task automatic test_reset_mid();
    logic [22:0] got;
    b2.res_ready = 1'b1;
    b2.cmd_op = 3'b000;
    b2.cmd_a = 4'd1;
    b2.cmd_b = 4'd1;
    b2.cmd_count = 4'd2;
    b2.cmd_valid = 1'b1;
    @(posedge clk); #1;
    b2.cmd_valid = 1'b0;
    @(posedge clk); #1;
    nvec++;
    if ({busy2, b2.alu_a, b2.alu_b} !== 9'b1_0001_0001) begin
      nerr++; $display("FAIL mid_setup: got %b want 100010001", {busy2, b2.alu_a, b2.alu_b});
    end
    #2 rst_n = 1'b0;
    #1;
    got = {b2.cmd_ready, b2.res_valid, b2.res_data, b2.res_flags, b2.res_err, b2.alu_op, b2.alu_a, b2.alu_b, busy2};
    nvec++;
    if (got !== {1'b1, 22'b0}) begin nerr++; $display("FAIL mid_async_reset: got %h want %h", got, {1'b1, 22'b0}); end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      nvec++;
      if ({b2.res_valid, b2.cmd_ready} !== 2'b01) begin
        nerr++; $display("FAIL mid_aborted[%0d]: got %b want 01", i, {b2.res_valid, b2.cmd_ready});
      end
    end
  endtask
  initial begin
    b0.cmd_valid = 1'b0; b0.cmd_op = '0; b0.cmd_a = '0; b0.cmd_b = '0; b0.cmd_count = '0; b0.res_ready = 1'b0;
    b2.cmd_valid = 1'b0; b2.cmd_op = '0; b2.cmd_a = '0; b2.cmd_b = '0; b2.cmd_count = '0; b2.res_ready = 1'b0;
    test_reset();
    test_single();
    test_chain();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Sequences the shared ALU and its 7-way result select: accepts one command at a time over a valid/ready handshake and drives op select and operands to the ALU. Chains repeated operations by feeding the registered result back as operand A, then returns the final result and flags over a second valid/ready handshake. Sits between the lab top-level/FPGA control logic and the combinational ALU + result mux.

Parameters:
P, 4, operand/result width in bits (matches ALU width)
CNT_W, 4, width of repeat-count field
ALU_LAT, 0, cycles of settling wait after driving ALU inputs before sampling result (0..3)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept command
cmd_op  input  3  ALU op select, 3'b000..3'b110 valid
cmd_a  input  P  initial operand A
cmd_b  input  P  operand B (held for all iterations)
cmd_count  input  CNT_W  iteration count; 0 treated as 1
alu_op  output  3  op select to ALU/result mux
alu_a  output  P  operand A to ALU
alu_b  output  P  operand B to ALU
alu_result  input  P  ALU mux output
alu_flags  input  4  {N,Z,C,V} from ALU
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  P  final result
res_flags  output  4  flags of final iteration
res_err  output  1  command had illegal op 3'b111
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE; cmd_ready=1, res_valid=0, res_data=0, res_flags=0, res_err=0, alu_op=3'b000, alu_a=0, alu_b=0, busy=0; all counters 0. Reset mid-command aborts it silently; no result is produced.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, DONE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch op, acc<=cmd_a, b<=cmd_b, remaining<=(cmd_count==0)?1:cmd_count. If op==3'b111, go to DONE with res_data=0, res_flags=0, res_err=1, and issue nothing to the ALU. Otherwise go to ISSUE.
- ISSUE: drive alu_op=op, alu_a=acc, alu_b=b. These outputs are registered and stay stable until the next ISSUE. Go to WAIT if ALU_LAT>0, else CAPTURE.
- WAIT: count ALU_LAT cycles, then go to CAPTURE.
- CAPTURE: acc<=alu_result, flags<=alu_flags, remaining<=remaining-1. If remaining==1, go to DONE; else go to ISSUE.
- DONE: res_valid=1; res_data/res_flags/res_err are held stable while res_valid && !res_ready. On res_ready, go to IDLE with res_valid=0 and res_err cleared.
- cmd_ready=0 in every state except IDLE; there is no command queuing.
- Latency with ALU_LAT=0: the cmd handshake cycle is followed by 2 cycles per iteration, then res_valid. For N iterations, res_valid rises N*(2+ALU_LAT)+1 cycles after the accept edge.
- Arithmetic: the sequencer does no arithmetic on data. Results wrap at P bits exactly as the ALU produces them. remaining is CNT_W bits; cmd_count at maximum (all ones) runs 2^CNT_W-1 iterations.
- cmd_* inputs are ignored outside IDLE. res_ready is ignored outside DONE.

Optional Feature:
ALU_OP_SEQ_STATS_EN
- Defined: adds outputs stat_cmds[15:0] (completed commands, including error commands) and stat_iters[15:0] (CAPTURE cycles), plus input stat_clr (synchronous clear, has priority over increment).
  - Counters saturate at 16'hFFFF.
  - Both counters reset to 0 on rst_n.
- Undefined: these ports and counters do not exist; the core behaviour is unchanged.

Decomposition:
- Package alu_pkg:
  - op typedef (3-bit enum OP_1..OP_7, OP_ILLEGAL=3'b111)
  - flags struct {n,z,c,v}
  - sequencer state enum
- No sub-module is required for the core.
- Stats logic goes in sub-module alu_op_seq_stats, instantiated only under ALU_OP_SEQ_STATS_EN.

Test Plan:
Bench ALU model: 3'b000 = A+B, 3'b001 = A−B; flags from the model. P=4 unless stated.
- Reset mid-command: apply reset during WAIT (ALU_LAT=2) -> all outputs return to reset values asynchronously; after release, cmd_ready=1 and no res_valid ever appears for the aborted command.
- Single ADD, op=000, A=3, B=4, count=1, res_ready=1 -> res_data=7, flags Z=0, res_err=0; res_valid 3 cycles after accept (ALU_LAT=0).
- Chained ADD with wrap, op=000, A=9, B=3, count=3 -> 9+3+3+3=18 mod 16=2; C=1 on final iteration; stat_iters +=3 with stats enabled.
- Backpressure: SUB A=5, B=5, count=0, res_ready held low 10 cycles -> res_data=0, Z=1, held stable; cmd_ready=0 throughout; cmd_valid pulses are ignored; returns to IDLE the cycle after res_ready=1.
- Illegal op 3'b111 with A=F -> alu_op never leaves its previous value; res_err=1, res_data=0; res_valid 1 cycle after accept.
